sa18_row_drain: RTL and testbench
=================================

# sa18_row_drain

Drain controller and output buffer that sits directly downstream of the 18-mode systolic array. After a tile's accumulation completes, it sequences the array's `channel_out_reset` / `channel_out_en` row-select strobes and captures each selected row word (`row_num` rows of `out_width` bits). It buffers the words in a small FIFO and presents them to the next stage (requant/writeback) over a valid/ready stream, with back-pressure stopping the row stepping.

## Interface
- `row_num`, 32, array rows to drain per tile.
- `column_num`, 32, array columns (sets word width only).
- `pixel_width_18`, 16, per-lane result width.
- `out_width`, `pixel_width_18*4*column_num` (2048), row word width.
- `fifo_depth`, 4, output FIFO entries (power of two, ≥2).
- `row_idx_width`, `$clog2(row_num)`, row index width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request to drain one tile; sampled only in IDLE.
- `channel_out_reset` out 1: to array; high exactly one cycle (state CLR).
- `channel_out_en` out 1: to array; each high cycle advances the array row counter by one.
- `sa_out` in `out_width`: array row word (combinational from the array's registered row counter).
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accepts the head when `out_valid && out_ready`.
- `out_data` out `out_width`: head row word.
- `out_row_idx` out `row_idx_width`: row number of the head word.
- `out_last` out 1: head is row `row_num-1`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse, the cycle after the last row is popped.

## Operation
- States: IDLE, CLR, DRAIN, FLUSH.
- IDLE → CLR when `start`=1. `start` in any other state is ignored.
- CLR: assert `channel_out_reset`, which puts the array counter at all-ones (output zero). Clear `issued` and `captured` counters. Next state is DRAIN.
- DRAIN: assert `channel_out_en` (issue) when `issued < row_num` and `fifo_count + inflight < fifo_depth`. `inflight` is the issue registered from the previous cycle (0/1). Each issue increments `issued`.
- Capture: on the cycle after an issue (`inflight`=1), push `sa_out` with tag `captured` into the FIFO and increment `captured`. The FIFO is never pushed while full; the credit check guarantees this.
- DRAIN → FLUSH when `issued == row_num` and no issue is pending.
- FLUSH → IDLE when the row tagged `row_num-1` pops; `done` pulses on the next cycle.
- A push and a pop in the same cycle leave `fifo_count` unchanged. Read and write pointers wrap modulo `fifo_depth`.
- `out_data`, `out_row_idx` and `out_last` come from the FIFO head. They hold stable while `out_valid && !out_ready`.
- The block does not check the array's internal counter. The strict CLR-then-`row_num`-strobes sequence keeps the array counter equal to `issued-1`.

## Timing
- Reset values: `channel_out_reset`=0, `channel_out_en`=0, `out_valid`=0, `out_data`=0, `out_row_idx`=0, `out_last`=0, `busy`=0, `done`=0, state IDLE, FIFO empty, counters 0.
- Reset mid-operation: everything returns to reset values immediately. FIFO contents are discarded. The array must be re-cleared by the next CLR.
- Latency: `start` sampled at edge E0 → CLR in cycle 1 → first issue in cycle 2 → array counter = 0 after E2 → capture at E3 → `out_valid`=1 in cycle 4.
- Throughput: with `out_ready` held 1, one row per cycle. `out_valid` stays continuous for `row_num` cycles.
- Back-pressure: with `out_ready`=0, at most `fifo_depth` rows sit buffered or in flight. `channel_out_en` stays low until credit frees, and it resumes the cycle after a pop.
- `done` is combinationally independent of inputs (registered). `busy` drops in the same cycle `done` is high.

## Test plan
- Basic drain, `out_ready`=1, `sa_out` = row-counter-coded pattern: 32 words with idx 0..31 matching the pattern. `out_valid` is high in cycles 4–35, `out_last` in cycle 35, `done` in cycle 36. Exactly one `channel_out_reset` and 32 `channel_out_en` pulses.
- Stall: hold `out_ready`=0 from cycle 0 → exactly 4 words buffered, `channel_out_en` low afterwards. Release → remaining 28 words in order, no loss or duplication.
- Alternating `out_ready` (1,0,1,0…) → 32 words in order. `fifo_count` never exceeds 4. Head words stable during stalls.
- `start` pulsed again while `busy` → ignored: still 32 words and one `done`.
- Assert `reset` in cycle 10 mid-drain → all outputs 0 at once. A new `start` then yields a fresh CLR and a full 32-row drain starting from idx 0.
- Back-to-back tiles: `start` the cycle after `done` → the second tile follows the same 4-cycle latency, and its idx restarts at 0.

Source files
------------

// File: rtl/sa18_row_drain_if.sv
//------------------------------------------------------------------------------
// Module   : sa18_row_drain_if
// Brief    : Row-word output stream (valid/ready) from the systolic-array drain.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sa18_row_drain_if #(
  parameter int OUT_WIDTH     = 2048,
  parameter int ROW_IDX_WIDTH = 5
);
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_WIDTH-1:0]     out_data;
  logic [ROW_IDX_WIDTH-1:0] out_row_idx;
  logic                     out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row_idx,
    input  out_last,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/sa18_row_drain.sv
//------------------------------------------------------------------------------
// Module   : sa18_row_drain
// Brief    : Sequences array row-select strobes, buffers row words, streams out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sa18_row_drain #(
  parameter int ROW_NUM        = 32,
  parameter int COLUMN_NUM     = 32,
  parameter int PIXEL_WIDTH_18 = 16,
  parameter int OUT_WIDTH      = PIXEL_WIDTH_18 * 4 * COLUMN_NUM,
  parameter int FIFO_DEPTH     = 4,
  parameter int ROW_IDX_WIDTH  = $clog2(ROW_NUM)
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 start,
  output logic                      channel_out_reset,
  output logic                      channel_out_en,
  input  wire logic [OUT_WIDTH-1:0] sa_out,
  sa18_row_drain_if.master          out_if,
  output logic                      busy,
  output logic                      done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ISS_W = ROW_IDX_WIDTH + 1;

  localparam logic [ISS_W-1:0]         C_ROWS     = ISS_W'(ROW_NUM);
  localparam logic [CNT_W-1:0]         C_DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [ROW_IDX_WIDTH-1:0] C_LAST_IDX = ROW_IDX_WIDTH'(ROW_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_done;
  logic                     w_done_nxt;

  logic [ISS_W-1:0]         r_issued;
  logic [ROW_IDX_WIDTH-1:0] r_captured;
  logic                     r_inflight;

  logic [OUT_WIDTH-1:0]     r_mem_data [FIFO_DEPTH];
  logic [ROW_IDX_WIDTH-1:0] r_mem_idx  [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  logic                     w_all_issued;
  logic                     w_credit_ok;
  logic                     w_issue;
  logic                     w_push;
  logic                     w_valid;
  logic [ROW_IDX_WIDTH-1:0] w_head_idx;
  logic                     w_last;
  logic                     w_pop;
  logic                     w_last_pop;

  // A row in flight already owns a FIFO slot, so it counts against credit.
  assign w_all_issued = (r_issued == C_ROWS);
  assign w_credit_ok  = ((r_count + CNT_W'(r_inflight)) < C_DEPTH);
  assign w_issue      = (r_state == S_DRAIN) && !w_all_issued && w_credit_ok;
  assign w_push       = r_inflight;

  assign w_valid    = (r_count != '0);
  assign w_head_idx = r_mem_idx[r_rd_ptr];
  assign w_last     = w_valid && (w_head_idx == C_LAST_IDX);
  assign w_pop      = w_valid && out_if.out_ready;
  assign w_last_pop = w_pop && w_last;

  assign channel_out_reset  = (r_state == S_CLR);
  assign channel_out_en     = w_issue;
  assign busy               = (r_state != S_IDLE);
  assign done               = r_done;
  assign out_if.out_valid   = w_valid;
  assign out_if.out_data    = r_mem_data[r_rd_ptr];
  assign out_if.out_row_idx = w_head_idx;
  assign out_if.out_last    = w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // The final row can pop on the very cycle DRAIN finishes, so DRAIN may
  // return straight to IDLE without visiting FLUSH.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CLR;
      S_CLR:   w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_all_issued && !r_inflight) begin
          if (w_last_pop) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (w_last_pop) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issued   <= '0;
      r_captured <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (r_state == S_CLR) begin
        r_issued   <= '0;
        r_captured <= '0;
      end else begin
        if (w_issue) r_issued   <= r_issued + ISS_W'(1);
        if (w_push)  r_captured <= r_captured + ROW_IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_idx[i]  <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr] <= sa_out;
      r_mem_idx[r_wr_ptr]  <= r_captured;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sa18_row_drain.sv
//------------------------------------------------------------------------------
// Module   : tb_sa18_row_drain
// Brief    : Directed self-checking bench for sa18_row_drain with an array model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sa18_row_drain;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cor;
  logic          coe;
  logic [2047:0] sa_out;
  logic          busy;
  logic          done;
  int            n_pass = 0;
  int            n_total = 0;
  int            arr_ctr = -1;

  sa18_row_drain_if #(.OUT_WIDTH(2048), .ROW_IDX_WIDTH(5)) out_if ();

  sa18_row_drain dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .channel_out_reset (cor),
    .channel_out_en    (coe),
    .sa_out            (sa_out),
    .out_if            (out_if.master),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  function automatic logic [2047:0] pat(input int k);
    logic [2047:0] v;
    for (int i = 0; i < 64; i++) v[i*32 +: 32] = 32'hA500_0000 ^ (32'(k) << 8) ^ 32'(i);
    return v;
  endfunction

  // Array row counter: clear parks it at all-ones (word zero), each strobe steps it.
  always @(posedge clk) begin
    if (cor) arr_ctr <= -1;
    else if (coe) arr_ctr <= arr_ctr + 1;
  end
  assign sa_out = (arr_ctr < 0) ? '0 : pat(arr_ctr);

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({cor, coe, out_if.out_valid, out_if.out_last, busy, done} !== 6'b0)
      $display("FAIL reset_ctrl: got %b exp 000000", {cor, coe, out_if.out_valid, out_if.out_last, busy, done});
    else n_pass++;
    n_total++;
    if (out_if.out_data !== '0) $display("FAIL reset_data: got %h exp 0", out_if.out_data[31:0]);
    else n_pass++;
    n_total++;
    if (out_if.out_row_idx !== 5'd0) $display("FAIL reset_idx: got %0d exp 0", out_if.out_row_idx);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int nen = 0;
    @(negedge clk); start = 1'b1; out_if.out_ready = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin @(negedge clk); start = 1'b0; end
      n_total++;
      if (out_if.out_valid !== (c >= 4 && c <= 35)) $display("FAIL basic_valid c%0d: got %b", c, out_if.out_valid);
      else n_pass++;
      if (c >= 4 && c <= 35) begin
        n_total++;
        if (out_if.out_row_idx !== 5'(c - 4)) $display("FAIL basic_idx c%0d: got %0d exp %0d", c, out_if.out_row_idx, c - 4);
        else n_pass++;
        n_total++;
        if (out_if.out_data !== pat(c - 4)) $display("FAIL basic_data c%0d: got %h exp %h", c, out_if.out_data[31:0], pat(c - 4) >> 0);
        else n_pass++;
      end
      n_total++;
      if ({cor, coe, out_if.out_last, done, busy} !== {c == 1, c >= 2 && c <= 33, c == 35, c == 36, c >= 1 && c <= 35})
        $display("FAIL basic_ctrl c%0d: got %b", c, {cor, coe, out_if.out_last, done, busy});
      else n_pass++;
      nen += int'(coe);
    end
    n_total++;
    if (nen != 32) $display("FAIL basic_en_count: got %0d exp 32", nen);
    else n_pass++;
  endtask

  task automatic test_stall();
    int nen = 0;
    int got = 0;
    int ndone = 0;
    @(negedge clk); start = 1'b1; out_if.out_ready = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); start = 1'b0;
      nen += int'(coe);
    end
    n_total++;
    if (nen != 4) $display("FAIL stall_buffered: got %0d exp 4", nen);
    else n_pass++;
    n_total++;
    if ({out_if.out_valid, coe, out_if.out_row_idx} !== {2'b10, 5'd0}) $display("FAIL stall_head: got %b", {out_if.out_valid, coe, out_if.out_row_idx});
    else n_pass++;
    for (int k = 0; k < 200 && got < 32; k++) begin
      @(negedge clk); out_if.out_ready = 1'b1;
      nen += int'(coe);
      if (out_if.out_valid) begin
        n_total++;
        if (out_if.out_row_idx !== 5'(got) || out_if.out_data !== pat(got))
          $display("FAIL stall_word: got idx %0d exp %0d", out_if.out_row_idx, got);
        else n_pass++;
        got++;
      end
    end
    repeat (4) begin @(negedge clk); ndone += int'(done); end
    n_total++;
    if ({got, nen, ndone} !== {32'd32, 32'd32, 32'd1}) $display("FAIL stall_totals: got words %0d en %0d done %0d exp 32 32 1", got, nen, ndone);
    else n_pass++;
  endtask

  task automatic test_alternating();
    int nen = 0;
    int got = 0;
    int ndone = 0;
    logic          prev_stall = 1'b0;
    logic [4:0]    prev_idx = '0;
    logic [2047:0] prev_data = '0;
    @(negedge clk); start = 1'b1; out_if.out_ready = 1'b1;
    for (int c = 0; c < 200 && got < 32; c++) begin
      if (c > 0) begin @(negedge clk); start = 1'b0; out_if.out_ready = (c % 2 == 0); end
      nen += int'(coe);
      if (prev_stall) begin
        n_total++;
        if (out_if.out_row_idx !== prev_idx || out_if.out_data !== prev_data)
          $display("FAIL alt_hold c%0d: got idx %0d exp %0d", c, out_if.out_row_idx, prev_idx);
        else n_pass++;
      end
      if (out_if.out_valid && out_if.out_ready) begin
        n_total++;
        if (out_if.out_row_idx !== 5'(got) || out_if.out_data !== pat(got))
          $display("FAIL alt_word: got idx %0d exp %0d", out_if.out_row_idx, got);
        else n_pass++;
        got++;
      end
      n_total++;
      if (nen - got > 4) $display("FAIL alt_occupancy c%0d: got %0d exp <=4", c, nen - got);
      else n_pass++;
      prev_stall = out_if.out_valid && !out_if.out_ready;
      prev_idx   = out_if.out_row_idx;
      prev_data  = out_if.out_data;
    end
    repeat (4) begin @(negedge clk); ndone += int'(done); end
    n_total++;
    if ({got, nen, ndone} !== {32'd32, 32'd32, 32'd1}) $display("FAIL alt_totals: got words %0d en %0d done %0d exp 32 32 1", got, nen, ndone);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int ncor = 0;
    int got = 0;
    int ndone = 0;
    @(negedge clk); start = 1'b1; out_if.out_ready = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk); start = (c == 10 || c == 20);
      ncor += int'(cor);
      ndone += int'(done);
      if (out_if.out_valid) begin
        n_total++;
        if (out_if.out_row_idx !== 5'(got)) $display("FAIL ign_idx: got %0d exp %0d", out_if.out_row_idx, got);
        else n_pass++;
        got++;
      end
    end
    n_total++;
    if ({ncor, got, ndone} !== {32'd1, 32'd32, 32'd1}) $display("FAIL ign_totals: got clr %0d words %0d done %0d exp 1 32 1", ncor, got, ndone);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int got = 0;
    @(negedge clk); start = 1'b1; out_if.out_ready = 1'b1;
    for (int c = 1; c <= 9; c++) begin @(negedge clk); start = 1'b0; end
    @(negedge clk); reset = 1'b1;
    #1;
    n_total++;
    if ({cor, coe, out_if.out_valid, out_if.out_last, busy, done, out_if.out_row_idx} !== 11'b0)
      $display("FAIL rstmid_ctrl: got %b exp 0", {cor, coe, out_if.out_valid, out_if.out_last, busy, done, out_if.out_row_idx});
    else n_pass++;
    n_total++;
    if (out_if.out_data !== '0) $display("FAIL rstmid_data: got %h exp 0", out_if.out_data[31:0]);
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); start = 1'b0;
      n_total++;
      if ({cor, done} !== {c == 1, c == 36}) $display("FAIL rstmid_seq c%0d: got %b", c, {cor, done});
      else n_pass++;
      if (out_if.out_valid) begin
        n_total++;
        if (out_if.out_row_idx !== 5'(got) || out_if.out_data !== pat(got))
          $display("FAIL rstmid_word: got idx %0d exp %0d", out_if.out_row_idx, got);
        else n_pass++;
        got++;
      end
    end
    n_total++;
    if (got != 32) $display("FAIL rstmid_count: got %0d exp 32", got);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit       ev;
    int       ei;
    @(negedge clk); start = 1'b1; out_if.out_ready = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk); start = (c == 37);
      ev = (c >= 4 && c <= 35) || (c >= 41 && c <= 72);
      ei = (c >= 41) ? c - 41 : c - 4;
      n_total++;
      if ({out_if.out_valid, cor, done} !== {ev, c == 1 || c == 38, c == 36 || c == 73})
        $display("FAIL b2b_ctrl c%0d: got %b", c, {out_if.out_valid, cor, done});
      else n_pass++;
      if (ev) begin
        n_total++;
        if (out_if.out_row_idx !== 5'(ei) || out_if.out_data !== pat(ei))
          $display("FAIL b2b_word c%0d: got idx %0d exp %0d", c, out_if.out_row_idx, ei);
        else n_pass++;
      end
    end
  endtask

  initial begin
    out_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_alternating();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
